lc_token_reader: RTL and testbench

- Requester-side engine for the lifecycle ROM read port (rd_en/addr in, rdData/valid out, one-cycle registered latency).
- Fetches one entry, or scans all entries, and compares each against a caller-supplied WIDTH-bit token.
- Reports match, matching index and error status to the lifecycle control logic.
- Sits between the lifecycle FSM/authentication logic and the lifecycle ROM.

---
 rtl/lc_pkg.sv | 20 ++
 rtl/lc_token_reader.sv | 132 +++++++++++++
 tb/tb_lc_token_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc_pkg.sv
// Shared lifecycle ROM definitions: default geometry, reader FSM states and error codes.
package lc_pkg;

  localparam int LC_WIDTH  = 256;
  localparam int LC_LENGTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } lc_rd_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_BADIDX  = 2'b10
  } lc_err_e;

endpackage

// File: rtl/lc_token_reader.sv
// Lifecycle ROM reader: fetches one entry or scans all entries and compares
// each against a caller token, reporting match, first matching index and error.
module lc_token_reader
  import lc_pkg::*;
#(
  parameter int WIDTH   = LC_WIDTH,
  parameter int LENGTH  = LC_LENGTH,
  parameter int TIMEOUT = 8,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    idx,
  input  logic [WIDTH-1:0] token,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [AW-1:0]    match_idx,
  output logic [1:0]       err,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdData,
  input  logic             mem_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

  lc_rd_state_e     state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] token_q, token_d;
  logic [AW-1:0]    cur_q, cur_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             match_q, match_d;
  logic [AW-1:0]    match_idx_q, match_idx_d;
  lc_err_e          err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      token_q     <= '0;
      cur_q       <= '0;
      wait_cnt_q  <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      token_q     <= token_d;
      cur_q       <= cur_d;
      wait_cnt_q  <= wait_cnt_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    token_d     = token_q;
    cur_d       = cur_q;
    wait_cnt_d  = wait_cnt_q;
    match_d     = match_q;
    match_idx_d = match_idx_q;
    err_d       = err_q;
    mem_rd_en   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          token_d     = token;
          match_d     = 1'b0;
          match_idx_d = '0;
          err_d       = ERR_NONE;
          // An out-of-range single index never touches the ROM and keeps cur in range.
          if (!mode && (idx > LAST)) begin
            cur_d   = '0;
            err_d   = ERR_BADIDX;
            state_d = DONE;
          end else begin
            cur_d   = mode ? '0 : idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_rd_en  = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          if (mem_rdData == token_q) begin
            match_d     = 1'b1;
            match_idx_d = cur_q;
            state_d     = DONE;
          end else if (!mode_q || (cur_q == LAST)) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_q + AW'(1);
            state_d = ISSUE;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          err_d   = ERR_TIMEOUT;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign mem_addr  = cur_q;
  assign match     = match_q;
  assign match_idx = match_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lc_token_reader.sv
// Bench for lc_token_reader: directed requests against a one-cycle ROM stub,
// with a per-cycle model of busy/done/read/result timing plus literal result checks.
module tb_lc_token_reader;

  localparam int WIDTH   = 256;
  localparam int LENGTH  = 6;
  localparam int TIMEOUT = 8;
  localparam int AW      = $clog2(LENGTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] token;
  logic             busy;
  logic             done;
  logic             match;
  logic [AW-1:0]    match_idx;
  logic [1:0]       err;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdData;
  logic             mem_valid;

  logic [WIDTH-1:0] rom [8];
  logic             rom_on;
  logic             stray;
  logic [WIDTH-1:0] stray_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int reads_total = 0;
  int read_base = 0;

  bit          req_valid = 1'b0;
  int          req_t = 0;
  int          req_lat = 0;
  int          req_reads = 0;
  logic        req_mode = 1'b0;
  logic [2:0]  req_idx = '0;
  logic        exp_match = 1'b0;
  logic [2:0]  exp_idx = '0;
  logic [1:0]  exp_err = '0;
  logic        prev_match = 1'b0;
  logic [2:0]  prev_idx = '0;
  logic [1:0]  prev_err = '0;

  lc_token_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .idx        (idx),
    .token      (token),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .match_idx  (match_idx),
    .err        (err),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdData (mem_rdData),
    .mem_valid  (mem_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mem_valid  <= (mem_rd_en && rom_on) || stray;
    mem_rdData <= stray ? stray_data : rom[mem_addr];
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [2:0] i, input logic [WIDTH-1:0] tok);
    int k;
    start = 1'b1;
    mode  = m;
    idx   = i;
    token = tok;
    if (req_valid && (cyc - req_t >= 1) && (cyc - req_t <= req_lat)) begin
      $display("[TB] start at cycle %0d while busy, expecting it ignored", cyc);
    end else begin
      prev_match = req_valid ? exp_match : 1'b0;
      prev_idx   = req_valid ? exp_idx : 3'd0;
      prev_err   = req_valid ? exp_err : 2'd0;
      req_mode   = m;
      req_idx    = i;
      exp_match  = 1'b0;
      exp_idx    = '0;
      exp_err    = 2'b00;
      if (!m && (i >= 3'd6)) begin
        req_lat = 1; req_reads = 0; exp_err = 2'b10;
      end else if (!rom_on) begin
        req_lat = TIMEOUT + 2; req_reads = 1; exp_err = 2'b01;
      end else if (!m) begin
        req_lat = 3; req_reads = 1;
        if (rom[i] == tok) begin exp_match = 1'b1; exp_idx = i; end
      end else begin
        k = -1;
        for (int e = LENGTH - 1; e >= 0; e--) if (rom[e] == tok) k = e;
        if (k >= 0) begin
          req_lat = 2 * k + 3; req_reads = k + 1; exp_match = 1'b1; exp_idx = 3'(k);
        end else begin
          req_lat = 2 * LENGTH + 1; req_reads = LENGTH;
        end
      end
      req_valid = 1'b1;
      req_t     = cyc;
      read_base = reads_total;
    end
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(input int lit_lat, input int lit_reads, input logic lit_match,
                          input logic [2:0] lit_idx, input logic [1:0] lit_err);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", longint'(seen), 1);
    if (seen) begin
      checkOutput("latency", longint'(cyc - req_t), longint'(lit_lat));
      checkOutput("rom_reads", longint'(reads_total - read_base), longint'(lit_reads));
      checkOutput("lit_match", longint'(match), longint'(lit_match));
      checkOutput("lit_match_idx", longint'(match_idx), longint'(lit_idx));
      checkOutput("lit_err", longint'(err), longint'(lit_err));
    end
    @(posedge clk); #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, longint'(busy), 0);
    checkOutput({tag, "_done"}, longint'(done), 0);
    checkOutput({tag, "_match"}, longint'(match), 0);
    checkOutput({tag, "_match_idx"}, longint'(match_idx), 0);
    checkOutput({tag, "_err"}, longint'(err), 0);
    checkOutput({tag, "_rd_en"}, longint'(mem_rd_en), 0);
    checkOutput({tag, "_addr"}, longint'(mem_addr), 0);
  endtask

  // Per-cycle comparison of every output against the timing model.
  initial begin
    int rel;
    logic e_busy, e_done, e_rd, e_match;
    logic [2:0] e_idx, e_addr;
    logic [1:0] e_err;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkAllZero("rst");
      end else begin
        rel    = cyc - req_t;
        e_busy = req_valid && (rel >= 1) && (rel <= req_lat);
        e_done = req_valid && (rel == req_lat);
        e_rd   = req_valid && (rel >= 1) && ((rel - 1) % 2 == 0) && ((rel - 1) / 2 < req_reads);
        e_addr = req_mode ? 3'((rel - 1) / 2) : req_idx;
        if (!req_valid || rel <= 0) begin
          e_match = prev_match; e_idx = prev_idx; e_err = prev_err;
        end else if (rel < req_lat) begin
          e_match = 1'b0; e_idx = '0; e_err = 2'b00;
        end else begin
          e_match = exp_match; e_idx = exp_idx; e_err = exp_err;
        end
        checkOutput("busy", longint'(busy), longint'(e_busy));
        checkOutput("done", longint'(done), longint'(e_done));
        checkOutput("mem_rd_en", longint'(mem_rd_en), longint'(e_rd));
        if (e_rd) checkOutput("mem_addr", longint'(mem_addr), longint'(e_addr));
        checkOutput("match", longint'(match), longint'(e_match));
        checkOutput("match_idx", longint'(match_idx), longint'(e_idx));
        checkOutput("err", longint'(err), longint'(e_err));
      end
      if (mem_rd_en) reads_total++;
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; idx = '0; token = '0;
    rom_on = 1'b1; stray = 1'b0; stray_data = '0;
    rom[0] = 256'h33a344a3_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_1357a24a;
    rom[1] = 256'h33a344a3_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_1357a24a;
    rom[2] = 256'h988b6a57_deadbeef_cafef00d_01020304_05060708_090a0b0c_0d0e0f10_11223348;
    rom[3] = 256'h5555aaaa_5555aaaa_5555aaaa_5555aaaa_5555aaaa_5555aaaa_5555aaaa_5555aaaa;
    rom[4] = 256'h0badc0de_12345678_9abcdef0_0fedcba9_87654321_ffffffff_00000000_76543210;
    rom[5] = 256'hc3e0fed6_a1b2c3d4_e5f60718_293a4b5c_6d7e8f90_abcdef01_23456789_feed01e5;
    rom[6] = '0;
    rom[7] = '0;

    #1;
    checkAllZero("reset_state");
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    applyStimulus(1'b0, 3'd2, rom[2]);  waitDone(3, 1, 1'b1, 3'd2, 2'b00);
    applyStimulus(1'b0, 3'd3, rom[2]);  waitDone(3, 1, 1'b0, 3'd0, 2'b00);
    applyStimulus(1'b1, 3'd0, rom[0]);  waitDone(3, 1, 1'b1, 3'd0, 2'b00);
    applyStimulus(1'b1, 3'd0, rom[5]);  waitDone(13, 6, 1'b1, 3'd5, 2'b00);
    applyStimulus(1'b1, 3'd0, '0);      waitDone(13, 6, 1'b0, 3'd0, 2'b00);
    applyStimulus(1'b0, 3'd7, rom[0]);  waitDone(1, 0, 1'b0, 3'd0, 2'b10);

    applyStimulus(1'b0, 3'd6, rom[0]);
    applyStimulus(1'b1, 3'd0, rom[0]);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("done_cycle_start_busy", longint'(busy), 0);
    checkOutput("done_cycle_start_err", longint'(err), 2);

    rom_on = 1'b0;
    applyStimulus(1'b0, 3'd1, rom[1]);  waitDone(10, 1, 1'b0, 3'd0, 2'b01);
    rom_on = 1'b1;

    stray_data = rom[1];
    stray = 1'b1;
    @(posedge clk); #2;
    stray = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("late_valid_err", longint'(err), 1);
    checkOutput("late_valid_match", longint'(match), 0);
    checkOutput("late_valid_busy", longint'(busy), 0);

    applyStimulus(1'b1, 3'd0, '0);
    repeat (7) @(posedge clk);
    #2;
    checkOutput("addr_at_cur3", longint'(mem_addr), 3);
    rst = 1'b0;
    req_valid = 1'b0; prev_match = 1'b0; prev_idx = '0; prev_err = '0;
    exp_match = 1'b0; exp_idx = '0; exp_err = '0;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    applyStimulus(1'b1, 3'd0, rom[4]);
    repeat (2) @(posedge clk);
    #2;
    applyStimulus(1'b0, 3'd2, rom[2]);
    waitDone(11, 5, 1'b1, 3'd4, 2'b00);

    applyStimulus(1'b0, 3'd5, rom[5]);  waitDone(3, 1, 1'b1, 3'd5, 2'b00);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
